// File: rtl/systolic_pkg.sv
// Shared types and elaboration checks for the systolic array processing elements.
// Other rtl files import this with import systolic_pkg::*.
`ifndef SYSTOLIC_PKG_SV
`define SYSTOLIC_PKG_SV

package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A 1-deep window still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// The full product of two WORD_WIDTH operands must fit in the accumulator.
`define SYSTOLIC_ACC_WIDTH_CHECK(ACC_W, WORD_W) \
    if ((ACC_W) < 2 * (WORD_W)) begin : g_acc_width_check \
        $error("systolic: ACC_WIDTH must be >= 2*WORD_WIDTH"); \
    end

`endif

// File: rtl/systolic_pe_if.sv
// Bus between a processing element and its neighbours / controller.
// act_valid_in qualifies act_in for one cycle; no backpressure exists, the PE
// always accepts, and acc_valid is a one-cycle pulse qualifying acc_out/acc_ovf.
interface systolic_pe_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
);
    logic                  w_load;
    logic [WORD_WIDTH-1:0] w_in;
    logic                  flush;
    logic [WORD_WIDTH-1:0] act_in;
    logic                  act_valid_in;
    logic [WORD_WIDTH-1:0] act_out;
    logic                  act_valid_out;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  acc_valid;
    logic                  acc_ovf;
    logic                  busy;
    systolic_pkg::state_t  state;

    modport master (
        output w_load, w_in, flush, act_in, act_valid_in,
        input  act_out, act_valid_out, acc_out, acc_valid, acc_ovf, busy, state
    );

    modport slave (
        input  w_load, w_in, flush, act_in, act_valid_in,
        output act_out, act_valid_out, acc_out, acc_valid, acc_ovf, busy, state
    );
endinterface

// File: rtl/systolic_pe_adder.sv
// Ripple-carry adder used by the accumulation path; cout is the carry out of the MSB.
module Adder #(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  cout
);

    always_comb begin
        logic c;
        c    = cin;
        sum  = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/systolic_pe.sv
// Weight-stationary PE: forwards activations east and accumulates act*weight
// over windows of ACC_DEPTH valid activations, pulsing acc_valid per window.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int ACC_DEPTH  = 4
) (
    input logic         clk,
    input logic         reset,
    systolic_pe_if.slave pe
);

    localparam int CNT_W = cnt_width(ACC_DEPTH);

    `SYSTOLIC_ACC_WIDTH_CHECK(ACC_WIDTH, WORD_WIDTH)

    if (ACC_DEPTH < 1) begin : g_depth_check
        $error("systolic_pe: ACC_DEPTH must be >= 1");
    end

    state_t                  state;
    logic [WORD_WIDTH-1:0]   weight;
    logic [ACC_WIDTH-1:0]    acc;
    logic [CNT_W-1:0]        count;
    logic                    ovf;

    logic [WORD_WIDTH-1:0]   act_q;
    logic                    act_valid_q;
    logic [ACC_WIDTH-1:0]    acc_out_q;
    logic                    acc_valid_q;
    logic                    acc_ovf_q;

    logic [2*WORD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    sum;
    logic                    cout;
    logic                    ovf_s;
    logic                    last;

    // Operands are widened first so the product keeps all 2*WORD_WIDTH bits.
    assign prod     = {{WORD_WIDTH{1'b0}}, pe.act_in} * {{WORD_WIDTH{1'b0}}, weight};
    assign prod_ext = ACC_WIDTH'(prod);
    assign ovf_s    = ovf | cout;
    assign last     = (count == CNT_W'(ACC_DEPTH - 1));

    Adder #(
        .WORD_WIDTH(ACC_WIDTH)
    ) u_adder (
        .a    (acc),
        .b    (prod_ext),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // East forwarding is independent of the window FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q       <= '0;
            act_valid_q <= 1'b0;
        end else begin
            act_q       <= pe.act_in;
            act_valid_q <= pe.act_valid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            weight      <= '0;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pe.w_load) begin
                        state  <= RUN;
                        weight <= pe.w_in;
                        acc    <= '0;
                        count  <= '0;
                        ovf    <= 1'b0;
                    end
                end
                RUN: begin
                    if (pe.flush) begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end else if (pe.w_load) begin
                        // Partial window is dropped; a same-cycle activation is not accumulated.
                        weight <= pe.w_in;
                        acc    <= '0;
                        count  <= '0;
                        ovf    <= 1'b0;
                    end else if (pe.act_valid_in) begin
                        if (last) begin
                            acc_out_q   <= sum;
                            acc_ovf_q   <= ovf_s;
                            acc_valid_q <= 1'b1;
                            acc         <= '0;
                            count       <= '0;
                            ovf         <= 1'b0;
                        end else begin
                            acc   <= sum;
                            ovf   <= ovf_s;
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pe.act_out       = act_q;
    assign pe.act_valid_out = act_valid_q;
    assign pe.acc_out       = acc_out_q;
    assign pe.acc_valid     = acc_valid_q;
    assign pe.acc_ovf       = acc_ovf_q;
    assign pe.busy          = (state == RUN);
    assign pe.state         = state;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe (8-bit words, 16-bit accumulator, 4-deep windows):
// directed table, hand sequences and random traffic against a window-sum model.
module tb_systolic_pe;
    import systolic_pkg::*;

    localparam int WW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    systolic_pe_if #(.WORD_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

    systolic_pe #(
        .WORD_WIDTH(WW),
        .ACC_WIDTH (AW),
        .ACC_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pe    (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_vec  = 0;
    int n_err  = 0;
    int n_puls = 0;
    logic [AW:0] exp_q[$];

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_w;
    int          win[$];
    logic [WW-1:0] m_act_out;
    logic        m_avo;
    logic        m_accv;
    logic [AW-1:0] m_acc;
    logic        m_ovf;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_w = 0; win.delete();
        m_act_out = '0; m_avo = 0; m_accv = 0; m_acc = '0; m_ovf = 0;
        exp_q.delete();
    endtask

    // Window sum computed as a plain integer: any carry-out happened iff the total reached 2^AW.
    task automatic model_edge(input logic wl, input int wi, input logic fl, input int a, input logic av);
        int total;
        m_act_out = a[WW-1:0];
        m_avo     = av;
        m_accv    = 0;
        if (!m_run) begin
            if (wl) begin m_run = 1; m_w = wi; win.delete(); end
        end else if (fl) begin
            m_run = 0; win.delete();
        end else if (wl) begin
            m_w = wi; win.delete();
        end else if (av) begin
            win.push_back(a * m_w);
            if (win.size() == DEPTH) begin
                total = 0;
                foreach (win[i]) total += win[i];
                m_acc  = AW'(total % (1 << AW));
                m_ovf  = (total >= (1 << AW));
                m_accv = 1;
                exp_q.push_back({m_ovf, m_acc});
                win.delete();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [AW:0] e;
        check({tag, ".act_out"},   bus.act_out,       m_act_out);
        check({tag, ".act_vout"},  bus.act_valid_out, m_avo);
        check({tag, ".acc_valid"}, bus.acc_valid,     m_accv);
        check({tag, ".acc_out"},   bus.acc_out,       m_acc);
        check({tag, ".acc_ovf"},   bus.acc_ovf,       m_ovf);
        check({tag, ".busy"},      bus.busy,          m_run);
        check({tag, ".state"},     (bus.state == RUN), m_run);
        if (bus.acc_valid === 1'b1) begin
            n_puls++;
            if (exp_q.size() == 0) begin
                check({tag, ".unexpected_pulse"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({tag, ".sb_result"}, {bus.acc_ovf, bus.acc_out}, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic wl, input int wi, input logic fl, input int a, input logic av,
                        input string tag);
        bus.w_load       = wl;
        bus.w_in         = wi[WW-1:0];
        bus.flush        = fl;
        bus.act_in       = a[WW-1:0];
        bus.act_valid_in = av;
        @(posedge clk);
        #1;
        model_edge(wl, wi, fl, a, av);
        check_outputs(tag);
    endtask

    task automatic act(input int a, input string tag);
        step(0, 0, 0, a, 1, tag);
    endtask

    task automatic gap(input string tag);
        step(0, 0, 0, 0, 0, tag);
    endtask

    // Reset asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset            = 1'b1;
        bus.w_load       = 0;
        bus.w_in         = '0;
        bus.flush        = 0;
        bus.act_in       = '0;
        bus.act_valid_in = 0;
        #1;
        model_reset();
        check({tag, ".rst_act_out"},   bus.act_out,       0);
        check({tag, ".rst_act_vout"},  bus.act_valid_out, 0);
        check({tag, ".rst_acc_out"},   bus.acc_out,       0);
        check({tag, ".rst_acc_valid"}, bus.acc_valid,     0);
        check({tag, ".rst_acc_ovf"},   bus.acc_ovf,       0);
        check({tag, ".rst_busy"},      bus.busy,          0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          wl;
        int            wi;
        logic          fl;
        int            a;
        logic          av;
        logic [WW-1:0] e_act_out;
        logic          e_avo;
        logic          e_accv;
        logic [AW-1:0] e_acc;
        logic          e_ovf;
        logic          e_busy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int p0;
        int w;
        int r;
        logic wl, fl, av;

        reset = 1'b1;
        bus.w_load = 0; bus.w_in = '0; bus.flush = 0; bus.act_in = '0; bus.act_valid_in = 0;
        model_reset();

        tbl[0] = '{1, 3, 0, 0, 0,  8'd0, 0, 0, 16'd0,  0, 1};
        tbl[1] = '{0, 0, 0, 1, 1,  8'd1, 1, 0, 16'd0,  0, 1};
        tbl[2] = '{0, 0, 0, 2, 1,  8'd2, 1, 0, 16'd0,  0, 1};
        tbl[3] = '{0, 0, 0, 3, 1,  8'd3, 1, 0, 16'd0,  0, 1};
        tbl[4] = '{0, 0, 0, 4, 1,  8'd4, 1, 1, 16'd30, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 0,  8'd0, 0, 0, 16'd30, 0, 1};

        // 1. reset state, then an activation in IDLE is forwarded only
        do_reset("t1");
        step(0, 0, 0, 5, 1, "t1");
        check("t1.fwd5", bus.act_out, 5);
        gap("t1");

        // 2. back-to-back window from the table
        p0 = n_puls;
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wl, tbl[i].wi, tbl[i].fl, tbl[i].a, tbl[i].av, "t2");
            check("t2.tbl_act_out", bus.act_out,       tbl[i].e_act_out);
            check("t2.tbl_avo",     bus.act_valid_out, tbl[i].e_avo);
            check("t2.tbl_accv",    bus.acc_valid,     tbl[i].e_accv);
            check("t2.tbl_acc",     bus.acc_out,       tbl[i].e_acc);
            check("t2.tbl_ovf",     bus.acc_ovf,       tbl[i].e_ovf);
            check("t2.tbl_busy",    bus.busy,          tbl[i].e_busy);
        end
        check("t2.pulses", n_puls - p0, 1);

        // 3. gaps between activations
        step(1, 3, 0, 0, 0, "t3");
        act(1, "t3"); gap("t3"); act(2, "t3"); gap("t3"); gap("t3"); act(3, "t3"); act(4, "t3");
        check("t3.valid", bus.acc_valid, 1);
        check("t3.sum",   bus.acc_out,   30);
        gap("t3");

        // 4. wrapping window, then a clean one with the same weight
        step(1, 255, 0, 0, 0, "t4");
        for (int i = 0; i < 4; i++) act(255, "t4");
        check("t4.sum_wrap", bus.acc_out, 63492);
        check("t4.ovf_set",  bus.acc_ovf, 1);
        for (int i = 0; i < 4; i++) act(1, "t4");
        check("t4.sum_1020", bus.acc_out, 1020);
        check("t4.ovf_clr",  bus.acc_ovf, 0);
        gap("t4");
        check("t4.ovf_hold", bus.acc_ovf, 0);

        // 5. weight reload mid-window with a same-cycle activation
        p0 = n_puls;
        step(1, 3, 0, 0, 0, "t5");
        act(1, "t5"); act(2, "t5");
        step(1, 2, 0, 9, 1, "t5");
        check("t5.fwd9", bus.act_out, 9);
        for (int i = 0; i < 4; i++) act(1, "t5");
        check("t5.sum8",   bus.acc_out, 8);
        check("t5.pulses", n_puls - p0, 1);
        gap("t5");

        // 6. reset mid-window, acts in IDLE, flush in RUN
        p0 = n_puls;
        step(1, 7, 0, 0, 0, "t6");
        act(10, "t6"); act(11, "t6");
        do_reset("t6");
        for (int i = 0; i < 5; i++) act(i + 1, "t6");
        step(1, 4, 0, 0, 0, "t6");
        act(2, "t6"); act(3, "t6");
        step(0, 0, 1, 0, 0, "t6");
        check("t6.flush_idle", bus.busy, 0);
        act(5, "t6"); act(6, "t6");
        check("t6.no_pulse", n_puls - p0, 0);

        // 7. random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            wl = (r < 5);
            fl = (r >= 5 && r < 8);
            av = ($urandom_range(0, 99) < 65);
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
            step(wl, w, fl, $urandom_range(0, 255), av, "rnd");
        end
        gap("end");

        check("sb.exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
